// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver: prefix codes,
// framing FSM encoding and the layout of one queued key event.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK   = 8'hF0;
  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam int         KEY_ENTRY_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_entry_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] byte_in, input logic par_in);
    return ^{byte_in, par_in};
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Small show-ahead FIFO for decoded key events. Head data reads 0 when empty;
// a push into a full FIFO without a simultaneous pop is dropped and flagged.
module ps2_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             overflow
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  always_comb begin
    do_pop     = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push    = push & (~full | do_pop);
    overflow_d = push & full & ~do_pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = empty ? '0 : mem[rd_ptr_q];
  assign overflow = overflow_q;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host receiver: line synchroniser, framing FSM with parity,
// stop and timeout checks, break/extended prefix stripping and an event queue.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4,
  parameter bit CHECK_PARITY   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkKeyboard,
  input  logic       data,
  output logic [7:0] keyCode,
  output logic       keyBreak,
  output logic       keyExtended,
  output logic       keyValid,
  input  logic       keyReady,
  output logic       parityErr,
  output logic       frameErr,
  output logic       overflow
);

  localparam int            TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  logic [SYNC_STAGES-1:0] kclk_sync_q, kdat_sync_q;
  logic                   kclk_fall, kdat;

  ps2_state_e state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_hit;

  logic            frame_done_q, frame_done_d;
  logic            frame_bad_q, frame_bad_d;
  logic [7:0]      frame_byte_q, frame_byte_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;

  logic            brk_pend_q, brk_pend_d;
  logic            ext_pend_q, ext_pend_d;
  logic            key_push;
  key_entry_t      push_entry, head_entry;
  logic            fifo_empty;

  // Idle PS/2 lines are high, so the chains reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_sync_q <= '1;
      kdat_sync_q <= '1;
    end else begin
      kclk_sync_q <= {kclk_sync_q[SYNC_STAGES-2:0], clkKeyboard};
      kdat_sync_q <= {kdat_sync_q[SYNC_STAGES-2:0], data};
    end
  end

  assign kclk_fall = kclk_sync_q[SYNC_STAGES-1] & ~kclk_sync_q[SYNC_STAGES-2];
  assign kdat      = kdat_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sh_d         = sh_q;
    par_d        = par_q;
    to_cnt_d     = to_cnt_q;
    timeout_hit  = 1'b0;
    frame_done_d = 1'b0;
    frame_bad_d  = 1'b0;
    frame_byte_d = frame_byte_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    // A fall in the same cycle as the limit keeps the frame alive.
    if (state_q == IDLE || kclk_fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      timeout_hit = 1'b1;
      state_d     = IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (kclk_fall) begin
      case (state_q)
        IDLE: begin
          if (!kdat) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          sh_d      = {kdat, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = kdat;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (CHECK_PARITY && !odd_parity_ok(sh_q, par_q)) begin
            parity_err_d = 1'b1;
            frame_bad_d  = 1'b1;
          end else if (!kdat) begin
            frame_err_d  = 1'b1;
            frame_bad_d  = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            frame_byte_d = sh_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Prefix bytes only arm flags; the next real scan code carries and clears them.
  always_comb begin
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    key_push   = 1'b0;
    if (frame_bad_q) begin
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end else if (frame_done_q) begin
      if (frame_byte_q == PS2_BREAK) begin
        brk_pend_d = 1'b1;
      end else if (frame_byte_q == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else begin
        key_push   = 1'b1;
        brk_pend_d = 1'b0;
        ext_pend_d = 1'b0;
      end
    end
    if (timeout_hit) begin
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      frame_done_q <= 1'b0;
      frame_bad_q  <= 1'b0;
      frame_byte_q <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      brk_pend_q   <= 1'b0;
      ext_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      frame_done_q <= frame_done_d;
      frame_bad_q  <= frame_bad_d;
      frame_byte_q <= frame_byte_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      brk_pend_q   <= brk_pend_d;
      ext_pend_q   <= ext_pend_d;
    end
  end

  assign push_entry = {ext_pend_q, brk_pend_q, frame_byte_q};

  ps2_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (key_push),
    .wr_data  (push_entry),
    .pop      (keyReady),
    .rd_data  (head_entry),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign keyCode     = head_entry.code;
  assign keyBreak    = head_entry.brk;
  assign keyExtended = head_entry.ext;
  assign keyValid    = ~fifo_empty;
  assign parityErr   = parity_err_q;
  assign frameErr    = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver with a queue-based event model
// compared against the DUT every cycle, plus literal spot checks.
module tb_ps2_keyboard_receiver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, kclk, kdat, keyReady;
  logic [7:0] keyCode, np_code;
  logic       keyBreak, keyExtended, keyValid, parityErr, frameErr, overflow;
  logic       np_brk, np_ext, np_valid, np_par, np_frm, np_ovf;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  int last_t;

  logic [9:0] mq [$];
  bit         brk_m, ext_m, e_par, e_frm, e_ovf;
  int         fr_t   = -1;
  int         push_t = -1;
  int         to_t   = -1;
  logic [7:0] fr_code;
  logic       fr_par, fr_stop;
  logic [9:0] push_ev;

  ps2_keyboard_receiver #(
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(200), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .clkKeyboard(kclk), .data(kdat),
    .keyCode(keyCode), .keyBreak(keyBreak), .keyExtended(keyExtended),
    .keyValid(keyValid), .keyReady(keyReady),
    .parityErr(parityErr), .frameErr(frameErr), .overflow(overflow)
  );

  ps2_keyboard_receiver #(
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(200), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b0)
  ) dut_np (
    .clk(clk), .rst(rst), .clkKeyboard(kclk), .data(kdat),
    .keyCode(np_code), .keyBreak(np_brk), .keyExtended(np_ext),
    .keyValid(np_valid), .keyReady(keyReady),
    .parityErr(np_par), .frameErr(np_frm), .overflow(np_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: state for the next cycle is derived from the frames the bench sent.
  always @(posedge clk) begin
    bit pop, full, n_par, n_frm, n_ovf;
    n_par = 1'b0; n_frm = 1'b0; n_ovf = 1'b0;
    if (!rst) begin
      mq.delete();
      brk_m = 1'b0; ext_m = 1'b0;
      push_t = -1; fr_t = -1; to_t = -1;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && keyReady;
      if (pop) mq.delete(0);
      if (cyc == push_t) begin
        if (full && !pop) n_ovf = 1'b1;
        else mq.push_back(push_ev);
      end
      if (cyc == fr_t) begin
        if (($countones({fr_code, fr_par}) % 2) == 0) begin
          n_par = 1'b1; brk_m = 1'b0; ext_m = 1'b0;
        end else if (!fr_stop) begin
          n_frm = 1'b1; brk_m = 1'b0; ext_m = 1'b0;
        end else if (fr_code == 8'hF0) begin
          brk_m = 1'b1;
        end else if (fr_code == 8'hE0) begin
          ext_m = 1'b1;
        end else begin
          push_ev = {ext_m, brk_m, fr_code};
          push_t  = cyc + 1;
          brk_m = 1'b0; ext_m = 1'b0;
        end
      end
      if (cyc == to_t) begin
        n_frm = 1'b1; brk_m = 1'b0; ext_m = 1'b0;
      end
    end
    e_par = n_par; e_frm = n_frm; e_ovf = n_ovf;
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    logic [9:0] eh;
    bit         ev;
    ev = (mq.size() != 0);
    eh = ev ? mq[0] : 10'h000;
    check("cycle_outputs",
          {18'b0, keyValid, keyExtended, keyBreak, keyCode, parityErr, frameErr, overflow},
          {18'b0, ev, eh, e_par, e_frm, e_ovf});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic ps2_fall(input logic b);
    wait_clk(10);
    kdat = b;
    wait_clk(10);
    kclk   = 1'b0;
    last_t = cyc + 1;
  endtask

  task automatic ps2_rise();
    wait_clk(20);
    kclk = 1'b1;
  endtask

  // Returns right after the stop-bit fall so callers can check exact cycles.
  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
    logic par;
    par = (~^b) ^ flip_par;
    $display("[TB] frame 0x%02h parity %0d stop %0d", b, par, stop);
    ps2_fall(1'b0); ps2_rise();
    for (int i = 0; i < 8; i++) begin
      ps2_fall(b[i]); ps2_rise();
    end
    ps2_fall(par); ps2_rise();
    fr_code = b; fr_par = par; fr_stop = stop;
    ps2_fall(stop);
    fr_t = last_t;
  endtask

  task automatic end_frame();
    ps2_rise();
    kdat = 1'b1;
    wait_clk(20);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits, input bit arm_timeout,
                              output int lt);
    $display("[TB] partial frame 0x%02h, %0d data bits", b, nbits);
    ps2_fall(1'b0); ps2_rise();
    for (int i = 0; i < nbits; i++) begin
      ps2_fall(b[i]);
      if (i == nbits - 1 && arm_timeout) to_t = last_t + 199;
      ps2_rise();
    end
    lt   = last_t;
    kdat = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b0; kclk = 1'b1; kdat = 1'b1; keyReady = 1'b1;
    wait_clk(3);
    check("reset_outputs", {keyValid, keyCode, keyBreak, keyExtended, parityErr, frameErr, overflow}, 0);
    #2 rst = 1'b1;
    wait_clk(5);

    // Make code with exact latency
    send_frame(8'h1C, 1'b0, 1'b1); t = last_t;
    wait_until(t + 1);
    check("make_valid_t1", keyValid, 0);
    check("make_no_err", {parityErr, frameErr}, 0);
    wait_until(t + 2);
    check("make_valid_t2", keyValid, 1);
    check("make_code", keyCode, 8'h1C);
    check("make_flags", {keyBreak, keyExtended}, 0);
    end_frame();

    // Extended break then plain make
    send_frame(8'hE0, 1'b0, 1'b1); end_frame();
    send_frame(8'hF0, 1'b0, 1'b1); end_frame();
    send_frame(8'h75, 1'b0, 1'b1); t = last_t;
    wait_until(t + 2);
    check("extbrk_code", keyCode, 8'h75);
    check("extbrk_flags", {keyValid, keyBreak, keyExtended}, 3'b111);
    end_frame();
    send_frame(8'h1C, 1'b0, 1'b1); t = last_t;
    wait_until(t + 2);
    check("after_extbrk", {keyValid, keyBreak, keyExtended, keyCode}, {3'b100, 8'h1C});
    end_frame();

    // Parity error clears a pending break; parity-ignoring instance queues it
    send_frame(8'hF0, 1'b0, 1'b1); end_frame();
    send_frame(8'h1C, 1'b1, 1'b1); t = last_t;
    wait_until(t + 1);
    check("parity_pulse", parityErr, 1);
    check("np_no_parity_pulse", np_par, 0);
    wait_until(t + 2);
    check("parity_pulse_end", parityErr, 0);
    check("parity_no_event", keyValid, 0);
    check("np_event", {np_valid, np_brk, np_ext, np_code}, {3'b110, 8'h1C});
    end_frame();
    send_frame(8'h1C, 1'b0, 1'b1); t = last_t;
    wait_until(t + 2);
    check("after_parity", {keyValid, keyBreak, keyExtended, keyCode}, {3'b100, 8'h1C});
    end_frame();

    // Bad stop bit
    send_frame(8'h1C, 1'b0, 1'b0); t = last_t;
    wait_until(t + 1);
    check("stop_pulse", {parityErr, frameErr}, 2'b01);
    wait_until(t + 2);
    check("stop_no_event", keyValid, 0);
    end_frame();

    // Timeout after four data bits
    send_partial(8'h29, 4, 1'b1, t);
    wait_until(t + 199);
    check("timeout_early", frameErr, 0);
    wait_until(t + 200);
    check("timeout_pulse", frameErr, 1);
    wait_until(t + 201);
    check("timeout_pulse_end", frameErr, 0);
    wait_until(t + 250);
    send_frame(8'h29, 1'b0, 1'b1); t = last_t;
    wait_until(t + 2);
    check("after_timeout", {keyValid, keyBreak, keyExtended, keyCode}, {3'b100, 8'h29});
    end_frame();

    // Overflow with the consumer stalled
    keyReady = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] cv;
      cv = i[7:0];
      send_frame(cv, 1'b0, 1'b1); t = last_t;
      wait_until(t + 2);
      check("overflow_pulse", overflow, (i == 5) ? 1 : 0);
      end_frame();
    end
    keyReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_order", {keyValid, keyCode}, {1'b1, 8'(k + 1)});
      @(negedge clk);
    end
    check("drain_empty", keyValid, 0);
    wait_clk(5);

    // Reset in the middle of a frame with an event queued and a break pending
    keyReady = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1); end_frame();
    send_frame(8'hF0, 1'b0, 1'b1); end_frame();
    send_partial(8'h29, 3, 1'b0, t);
    wait_clk(2);
    check("pre_reset_valid", keyValid, 1);
    #2 rst = 1'b0;
    #1 check("midreset_outputs",
             {keyValid, keyCode, keyBreak, keyExtended, parityErr, frameErr, overflow}, 0);
    wait_clk(3);
    #2 rst = 1'b1;
    keyReady = 1'b1;
    wait_clk(5);
    send_frame(8'h1C, 1'b0, 1'b1); t = last_t;
    wait_until(t + 2);
    check("after_reset", {keyValid, keyBreak, keyExtended, keyCode}, {3'b100, 8'h1C});
    end_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
